// File: rtl/or_reduce_pipe.sv
// rtl/or_reduce_pipe.sv - pipelined N-input OR with inversion mask, edge detect, sticky flag and rise counter
//
// Parameters:
//   WIDTH    number of inputs (1..64)
//   INV_MASK bit i = 1 inverts din[i] before the OR
//   GROUP    fan-in per tree node per pipeline stage (2..8)
//   CNT_W    width of rise_cnt
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   en       din is a valid sample this cycle
//   din      raw inputs
//   clr      synchronous clear of sticky and rise_cnt
//   o        registered OR result of the last valid sample
//   o_valid  one-cycle pulse, o updated this cycle
//   rise     one-cycle pulse, o went 0->1 on this update
//   sticky   set on any valid result of 1, held until clr
//   rise_cnt saturating count of rise pulses
module or_reduce_pipe #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(5'b01111),
    parameter int               GROUP    = 4,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic             o,
    output logic             o_valid,
    output logic             rise,
    output logic             sticky,
    output logic [CNT_W-1:0] rise_cnt
);

    // Number of tree stages: smallest L >= 1 with GROUP^L >= WIDTH.
    function automatic int calc_depth(input int w, input int g);
        int     d;
        longint p;
        d = 1;
        p = g;
        while (p < w) begin
            p = p * g;
            d = d + 1;
        end
        return d;
    endfunction

    // Node count after k stages of GROUP-way reduction.
    function automatic int stage_w(input int w, input int g, input int k);
        int n;
        n = w;
        for (int i = 0; i < k; i++) begin
            n = (n + g - 1) / g;
        end
        return n;
    endfunction

    localparam int L = calc_depth(WIDTH, GROUP);

    logic [WIDTH-1:0] x;
    assign x = din ^ INV_MASK;

    for (genvar k = 1; k <= L; k++) begin : g_stage
        localparam int NI = stage_w(WIDTH, GROUP, k - 1);
        localparam int NO = stage_w(WIDTH, GROUP, k);

        logic [NI-1:0]       src;
        logic [NO*GROUP-1:0] pad;
        logic [NO-1:0]       stage_d;
        logic [NO-1:0]       stage_q;

        if (k == 1) begin : g_first
            assign src = x;
        end else begin : g_next
            assign src = g_stage[k-1].stage_q;
        end

        // Zero padding makes the trailing partial group a plain OR of fewer bits.
        always_comb begin
            pad         = '0;
            pad[NI-1:0] = src;
        end

        always_comb begin
            stage_d = '0;
            for (int j = 0; j < NO; j++) begin
                stage_d[j] = |pad[j*GROUP +: GROUP];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    logic tree_out;
    assign tree_out = g_stage[L].stage_q[0];

    // Valid bit for each tree stage; bit L-1 marks the sample leaving the tree.
    logic [L-1:0] vld_d, vld_q;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    logic             tree_vld;
    logic             o_d, o_q;
    logic             o_valid_d, o_valid_q;
    logic             rise_d, rise_q;
    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign tree_vld = vld_q[L-1];

    always_comb begin
        o_valid_d = tree_vld;
        o_d       = tree_vld ? tree_out : o_q;
        rise_d    = tree_vld & tree_out & ~o_q;
        // A new 1 result wins over a simultaneous clr.
        sticky_d  = (sticky_q & ~clr) | (tree_vld & tree_out);
        // clr zeroes the base first, so clr with a rise lands on 1.
        cnt_base  = clr ? '0 : cnt_q;
        cnt_d     = cnt_base;
        if (rise_d && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            rise_q    <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            rise_q    <= rise_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign rise     = rise_q;
    assign sticky   = sticky_q;
    assign rise_cnt = cnt_q;

endmodule
